// File: rtl/enc_defines.sv
// enc_defines: shared defaults for the deblocking buffers
package enc_defines;
  localparam int DB_WORD_W = 128;
  localparam int DB_ADDR_W = 5;
  function automatic int bank_num(input int bw);
    return 1 << bw;
  endfunction
endpackage

// File: rtl/db_ram_pp_dp_if.sv
// db_ram_pp_dp_if: producer/consumer bus of the ping-pong bank buffer
interface db_ram_pp_dp_if
  import enc_defines::*;
#(
  parameter int Word_Width = DB_WORD_W,
  parameter int Addr_Width = DB_ADDR_W,
  parameter int Bank_Width = 1
);
  logic                  a_cen_i;
  logic                  a_wen_i;
  logic [Addr_Width-1:0] a_addr_i;
  logic [Word_Width-1:0] a_data_i;
  logic [Word_Width-1:0] a_data_o;
  logic                  a_vld_o;
  logic                  a_done_i;
  logic                  a_rdy_o;
  logic [Bank_Width-1:0] a_bank_o;
  logic                  b_cen_i;
  logic [Addr_Width-1:0] b_addr_i;
  logic [Word_Width-1:0] b_data_o;
  logic                  b_vld_o;
  logic                  b_done_i;
  logic                  b_rdy_o;
  logic [Bank_Width-1:0] b_bank_o;
  logic [Bank_Width:0]   cnt_o;
  logic                  err_o;
  modport slave (
    input  a_cen_i, a_wen_i, a_addr_i, a_data_i, a_done_i, b_cen_i, b_addr_i, b_done_i,
    output a_data_o, a_vld_o, a_rdy_o, a_bank_o, b_data_o, b_vld_o, b_rdy_o, b_bank_o, cnt_o, err_o
  );
  modport master (
    output a_cen_i, a_wen_i, a_addr_i, a_data_i, a_done_i, b_cen_i, b_addr_i, b_done_i,
    input  a_data_o, a_vld_o, a_rdy_o, a_bank_o, b_data_o, b_vld_o, b_rdy_o, b_bank_o, cnt_o, err_o
  );
endinterface

// File: rtl/db_pp_ring_ctrl.sv
// db_pp_ring_ctrl: bank ring pointers, occupancy, access gating and sticky error
module db_pp_ring_ctrl #(
  parameter int Bank_Width = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  a_cen,
  input  logic                  a_done,
  input  logic                  b_cen,
  input  logic                  b_done,
  output logic [Bank_Width-1:0] wr_ptr,
  output logic [Bank_Width-1:0] rd_ptr,
  output logic [Bank_Width:0]   cnt,
  output logic                  a_rdy,
  output logic                  b_rdy,
  output logic                  a_ok,
  output logic                  b_ok,
  output logic                  err
);
  localparam logic [Bank_Width:0] Bank_Num = {1'b1, {Bank_Width{1'b0}}};
  logic a_cmt, b_rel, bad;
  always_comb begin
    a_rdy = cnt != Bank_Num;
    b_rdy = cnt != '0;
    a_ok  = !a_cen && a_rdy;
    b_ok  = !b_cen && b_rdy;
    a_cmt = a_done && a_rdy;
    b_rel = b_done && b_rdy;
    bad   = (!a_rdy && (a_done || !a_cen)) || (!b_rdy && (b_done || !b_cen));
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + Bank_Width'(a_cmt);
      rd_ptr <= rd_ptr + Bank_Width'(b_rel);
      cnt    <= cnt + (Bank_Width+1)'(a_cmt) - (Bank_Width+1)'(b_rel);
      err    <= err || bad;
    end
  end
endmodule

// File: rtl/ram_dp.sv
// ram_dp: dual-port SRAM, active-low enables, 1-cycle synchronous read
module ram_dp #(
  parameter int Word_Width = 128,
  parameter int Addr_Width = 6
) (
  input  logic                  clk,
  input  logic                  a_cen,
  input  logic                  a_wen,
  input  logic [Addr_Width-1:0] a_addr,
  input  logic [Word_Width-1:0] a_din,
  output logic [Word_Width-1:0] a_dout,
  input  logic                  b_cen,
  input  logic                  b_wen,
  input  logic [Addr_Width-1:0] b_addr,
  input  logic [Word_Width-1:0] b_din,
  output logic [Word_Width-1:0] b_dout
);
  logic [Word_Width-1:0] mem [2**Addr_Width];
  always_ff @(posedge clk) begin
    if (!a_cen && !a_wen) mem[a_addr] <= a_din;
    if (!a_cen && a_wen) a_dout <= mem[a_addr];
    if (!b_cen && !b_wen) mem[b_addr] <= b_din;
    if (!b_cen && b_wen) b_dout <= mem[b_addr];
  end
endmodule

// File: rtl/db_ram_pp_dp.sv
// db_ram_pp_dp: multi-bank ping-pong dual-port buffer with commit/release bank handoff
module db_ram_pp_dp
  import enc_defines::*;
#(
  parameter int Word_Width = DB_WORD_W,
  parameter int Addr_Width = DB_ADDR_W,
  parameter int Bank_Width = 1
) (
  input logic             clk,
  input logic             rstn,
  db_ram_pp_dp_if.slave   bus
);
  logic [Bank_Width-1:0] wr_ptr, rd_ptr;
  logic [Bank_Width:0]   cnt;
  logic                  a_rdy, b_rdy, a_ok, b_ok, err;
  logic                  a_vld, b_vld;
  logic [Word_Width-1:0] ra, rb, a_hold, b_hold;
  db_pp_ring_ctrl #(.Bank_Width(Bank_Width)) u_ctrl (
    .clk    (clk),
    .rstn   (rstn),
    .a_cen  (bus.a_cen_i),
    .a_done (bus.a_done_i),
    .b_cen  (bus.b_cen_i),
    .b_done (bus.b_done_i),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .cnt    (cnt),
    .a_rdy  (a_rdy),
    .b_rdy  (b_rdy),
    .a_ok   (a_ok),
    .b_ok   (b_ok),
    .err    (err)
  );
  ram_dp #(.Word_Width(Word_Width), .Addr_Width(Addr_Width + Bank_Width)) u_ram (
    .clk    (clk),
    .a_cen  (!a_ok),
    .a_wen  (bus.a_wen_i),
    .a_addr ({wr_ptr, bus.a_addr_i}),
    .a_din  (bus.a_data_i),
    .a_dout (ra),
    .b_cen  (!b_ok),
    .b_wen  (1'b1),
    .b_addr ({rd_ptr, bus.b_addr_i}),
    .b_din  ('0),
    .b_dout (rb)
  );
  // RAM outputs are shown only in the valid cycle; otherwise the last read word is held
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      a_vld  <= a_ok && bus.a_wen_i;
      b_vld  <= b_ok;
      a_hold <= a_vld ? ra : a_hold;
      b_hold <= b_vld ? rb : b_hold;
    end
  end
  always_comb begin
    bus.a_data_o = a_vld ? ra : a_hold;
    bus.b_data_o = b_vld ? rb : b_hold;
    bus.a_vld_o  = a_vld;
    bus.b_vld_o  = b_vld;
    bus.a_rdy_o  = a_rdy;
    bus.b_rdy_o  = b_rdy;
    bus.a_bank_o = wr_ptr;
    bus.b_bank_o = rd_ptr;
    bus.cnt_o    = cnt;
    bus.err_o    = err;
  end
endmodule

// File: tb/tb_db_ram_pp_dp.sv
// tb_db_ram_pp_dp: scoreboard bench for two-bank and four-bank ring buffers
module tb_db_ram_pp_dp;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int total = 0;
  int bad = 0;
  logic [127:0] qa1[$];
  logic [127:0] qb1[$];
  logic [127:0] qb2[$];
  always #5 clk = ~clk;
  db_ram_pp_dp_if #(.Word_Width(128), .Addr_Width(5), .Bank_Width(1)) b1 ();
  db_ram_pp_dp_if #(.Word_Width(32), .Addr_Width(5), .Bank_Width(2)) b2 ();
  db_ram_pp_dp #(.Word_Width(128), .Addr_Width(5), .Bank_Width(1)) u1 (.clk(clk), .rstn(rstn), .bus(b1));
  db_ram_pp_dp #(.Word_Width(32), .Addr_Width(5), .Bank_Width(2)) u2 (.clk(clk), .rstn(rstn), .bus(b2));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (b1.a_vld_o) begin
      if (qa1.size() == 0) chk("a1_spur", b1.a_vld_o, 0);
      else chk("a1_rd", b1.a_data_o, qa1.pop_front());
    end
    if (b1.b_vld_o) begin
      if (qb1.size() == 0) chk("b1_spur", b1.b_vld_o, 0);
      else chk("b1_rd", b1.b_data_o, qb1.pop_front());
    end
    if (b2.b_vld_o) begin
      if (qb2.size() == 0) chk("b2_spur", b2.b_vld_o, 0);
      else chk("b2_rd", {96'd0, b2.b_data_o}, qb2.pop_front());
    end
  end
  task automatic idle;
    b1.a_cen_i = 1; b1.a_wen_i = 1; b1.a_addr_i = 0; b1.a_data_i = 0; b1.a_done_i = 0;
    b1.b_cen_i = 1; b1.b_addr_i = 0; b1.b_done_i = 0;
    b2.a_cen_i = 1; b2.a_wen_i = 1; b2.a_addr_i = 0; b2.a_data_i = 0; b2.a_done_i = 0;
    b2.b_cen_i = 1; b2.b_addr_i = 0; b2.b_done_i = 0;
  endtask
  task automatic cyc;
    @(negedge clk);
    idle();
  endtask
  task automatic wr1(input int a, input logic [127:0] d);
    b1.a_cen_i = 0; b1.a_wen_i = 0; b1.a_addr_i = 5'(a); b1.a_data_i = d;
    cyc();
  endtask
  task automatic rda1(input int a, input logic [127:0] e);
    b1.a_cen_i = 0; b1.a_addr_i = 5'(a);
    qa1.push_back(e);
    cyc();
  endtask
  task automatic rdb1(input int a, input logic [127:0] e, input bit acc);
    b1.b_cen_i = 0; b1.b_addr_i = 5'(a);
    if (acc) qb1.push_back(e);
    cyc();
  endtask
  task automatic done1(input bit a, input bit b);
    b1.a_done_i = a; b1.b_done_i = b;
    cyc();
  endtask
  task automatic wr2(input int a, input int d);
    b2.a_cen_i = 0; b2.a_wen_i = 0; b2.a_addr_i = 5'(a); b2.a_data_i = 32'(d);
    cyc();
  endtask
  task automatic rst_pulse;
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
  endtask
  task automatic chk_rst1(input string tag);
    chk({tag, "_cnt"}, b1.cnt_o, 0);
    chk({tag, "_ardy"}, b1.a_rdy_o, 1);
    chk({tag, "_brdy"}, b1.b_rdy_o, 0);
    chk({tag, "_abank"}, b1.a_bank_o, 0);
    chk({tag, "_bbank"}, b1.b_bank_o, 0);
    chk({tag, "_avld"}, b1.a_vld_o, 0);
    chk({tag, "_bvld"}, b1.b_vld_o, 0);
    chk({tag, "_err"}, b1.err_o, 0);
    chk({tag, "_adata"}, b1.a_data_o, 0);
    chk({tag, "_bdata"}, b1.b_data_o, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    int cm, rl;
    idle();
    #1 rstn = 0;
    repeat (2) @(negedge clk);
    chk_rst1("rst");
    rstn = 1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) wr1(i, 128'(i));
    done1(1, 0);
    chk("c1_cnt", b1.cnt_o, 1);
    chk("c1_brdy", b1.b_rdy_o, 1);
    chk("c1_abank", b1.a_bank_o, 1);
    chk("c1_bbank", b1.b_bank_o, 0);
    chk("c1_err", b1.err_o, 0);
    rdb1(5, 5, 1);
    @(negedge clk);
    chk("b1_vld_1cyc", b1.b_vld_o, 0);
    chk("b1_hold", b1.b_data_o, 5);
    for (int i = 0; i < 32; i++) wr1(i, 128'(100 + i));
    wr1(3, 'hA);
    rda1(3, 'hA);
    done1(1, 0);
    chk("c2_cnt", b1.cnt_o, 2);
    chk("c2_ardy", b1.a_rdy_o, 0);
    chk("c2_err", b1.err_o, 0);
    done1(1, 0);
    wr1(5, 'hDEAD);
    chk("full_cnt", b1.cnt_o, 2);
    chk("full_abank", b1.a_bank_o, 0);
    chk("full_err", b1.err_o, 1);
    rdb1(5, 5, 1);
    rdb1(31, 31, 1);
    done1(0, 1);
    chk("rel_cnt", b1.cnt_o, 1);
    chk("rel_bbank", b1.b_bank_o, 1);
    chk("rel_ardy", b1.a_rdy_o, 1);
    rdb1(3, 'hA, 1);
    rdb1(7, 107, 1);
    done1(1, 1);
    chk("sim_cnt", b1.cnt_o, 1);
    chk("sim_abank", b1.a_bank_o, 1);
    chk("sim_bbank", b1.b_bank_o, 0);
    rdb1(9, 9, 1);
    rst_pulse();
    done1(0, 1);
    chk("emp_done_cnt", b1.cnt_o, 0);
    chk("emp_done_bbank", b1.b_bank_o, 0);
    chk("emp_done_err", b1.err_o, 1);
    rst_pulse();
    chk("rst2_err", b1.err_o, 0);
    rdb1(4, 0, 0);
    chk("emp_rd_vld", b1.b_vld_o, 0);
    chk("emp_rd_err", b1.err_o, 1);
    rst_pulse();
    wr1(0, 'h55);
    rda1(0, 'h55);
    done1(1, 0);
    done1(1, 0);
    chk("pre_cnt", b1.cnt_o, 2);
    chk("pre_adata", b1.a_data_o, 'h55);
    #3 rstn = 0;
    #1 chk_rst1("mid");
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    cm = 0;
    rl = 0;
    while (rl < 4) begin
      if (cm < 4 && (cm == rl || $urandom_range(1) == 1)) begin
        chk("b2_abank", b2.a_bank_o, cm);
        for (int i = 0; i < 4; i++) wr2(i == 3 ? 31 : i, cm * 256 + (i == 3 ? 31 : i));
        b2.a_done_i = 1;
        cyc();
        cm++;
      end else begin
        chk("b2_bbank", b2.b_bank_o, rl);
        b2.b_cen_i = 0; b2.b_addr_i = 0;
        qb2.push_back(128'(rl * 256));
        cyc();
        b2.b_cen_i = 0; b2.b_addr_i = 31; b2.b_done_i = 1;
        qb2.push_back(128'(rl * 256 + 31));
        cyc();
        rl++;
      end
      chk("b2_cnt", b2.cnt_o, cm - rl);
      chk("b2_ardy", b2.a_rdy_o, (cm - rl) != 4);
    end
    chk("b2_err", b2.err_o, 0);
    repeat (2) @(negedge clk);
    chk("qa1_left", qa1.size(), 0);
    chk("qb1_left", qb1.size(), 0);
    chk("qb2_left", qb2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
